// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86-64 pipeline stage register with stall/bubble control, event counters and hazard flag
module pipe_stage_reg #(
    parameter int               WORD_W    = 64,
    parameter int               REG_W     = 4,
    parameter int               STAT_W    = 2,
    parameter logic [3:0]       NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0] RNONE     = '1,
    parameter logic [STAT_W-1:0] STAT_AOK = '0,
    parameter int               CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [STAT_W-1:0] in_status,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [REG_W-1:0]  in_srca,
    input  logic [REG_W-1:0]  in_srcb,
    input  logic [REG_W-1:0]  in_dste,
    input  logic [REG_W-1:0]  in_dstm,
    input  logic [WORD_W-1:0] in_vala,
    input  logic [WORD_W-1:0] in_valb,
    input  logic [WORD_W-1:0] in_valc,
    input  logic              stall,
    input  logic              bubble,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [STAT_W-1:0] out_status,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_ifun,
    output logic [REG_W-1:0]  out_srca,
    output logic [REG_W-1:0]  out_srcb,
    output logic [REG_W-1:0]  out_dste,
    output logic [REG_W-1:0]  out_dstm,
    output logic [WORD_W-1:0] out_vala,
    output logic [WORD_W-1:0] out_valb,
    output logic [WORD_W-1:0] out_valc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              hazard_err
);

    typedef struct packed {
        logic              valid;
        logic [STAT_W-1:0] status;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [REG_W-1:0]  srca;
        logic [REG_W-1:0]  srcb;
        logic [REG_W-1:0]  dste;
        logic [REG_W-1:0]  dstm;
        logic [WORD_W-1:0] vala;
        logic [WORD_W-1:0] valb;
        logic [WORD_W-1:0] valc;
    } bundle_t;

    bundle_t            bundle_q, bundle_d, nop_bundle, in_bundle;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic               hazard_err_q, hazard_err_d;

    // Next-state selection: bubble beats stall beats load; counters saturate and clear wins over increment
    always_comb begin
        nop_bundle   = '{valid: 1'b0, status: STAT_AOK, icode: NOP_ICODE, ifun: 4'h0,
                         srca: RNONE, srcb: RNONE, dste: RNONE, dstm: RNONE,
                         vala: '0, valb: '0, valc: '0};
        in_bundle    = '{valid: in_valid, status: in_status, icode: in_icode, ifun: in_ifun,
                         srca: in_srca, srcb: in_srcb, dste: in_dste, dstm: in_dstm,
                         vala: in_vala, valb: in_valb, valc: in_valc};
        bundle_d     = bubble ? nop_bundle : stall ? bundle_q : in_bundle;
        stall_cnt_d  = clr_cnt ? '0
                     : (stall && !bubble && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1)
                     : stall_cnt_q;
        bubble_cnt_d = clr_cnt ? '0
                     : (bubble && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_W'(1)
                     : bubble_cnt_q;
        hazard_err_d = stall & bubble;
    end

    // State registers with synchronous active-low reset to the NOP bundle and cleared counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bundle_q     <= nop_bundle;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            hazard_err_q <= 1'b0;
        end else begin
            bundle_q     <= bundle_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            hazard_err_q <= hazard_err_d;
        end
    end

    assign out_valid  = bundle_q.valid;
    assign out_status = bundle_q.status;
    assign out_icode  = bundle_q.icode;
    assign out_ifun   = bundle_q.ifun;
    assign out_srca   = bundle_q.srca;
    assign out_srcb   = bundle_q.srcb;
    assign out_dste   = bundle_q.dste;
    assign out_dstm   = bundle_q.dstm;
    assign out_vala   = bundle_q.vala;
    assign out_valb   = bundle_q.valb;
    assign out_valc   = bundle_q.valc;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized self-checking bench for pipe_stage_reg against a rule-level model
module tb_pipe_stage_reg;

    logic        clock = 1'b0;
    logic        reset_n, in_valid, stall, bubble, clr_cnt;
    logic [1:0]  in_status;
    logic [3:0]  in_icode, in_ifun, in_srca, in_srcb, in_dste, in_dstm;
    logic [63:0] in_vala, in_valb, in_valc;

    logic        o_valid, o_haz, p_valid, p_haz;
    logic [1:0]  o_status, p_status;
    logic [3:0]  o_icode, o_ifun, o_srca, o_srcb, o_dste, o_dstm;
    logic [3:0]  p_icode, p_ifun, p_srca, p_srcb, p_dste, p_dstm;
    logic [63:0] o_vala, o_valb, o_valc, p_vala, p_valb, p_valc;
    logic [15:0] o_scnt, o_bcnt;
    logic [3:0]  p_scnt, p_bcnt;

    int errors = 0;
    int checks = 0;

    // Reference state: what the stage should be holding, plus raw event counts since last clear
    logic        m_valid, m_haz;
    logic [1:0]  m_status;
    logic [3:0]  m_icode, m_ifun, m_srca, m_srcb, m_dste, m_dstm;
    logic [63:0] m_vala, m_valb, m_valc;
    int          m_sn, m_bn;

    always #5 clock = ~clock;

    pipe_stage_reg dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_status(in_status),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_srca(in_srca), .in_srcb(in_srcb),
        .in_dste(in_dste), .in_dstm(in_dstm), .in_vala(in_vala), .in_valb(in_valb),
        .in_valc(in_valc), .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
        .out_valid(o_valid), .out_status(o_status), .out_icode(o_icode), .out_ifun(o_ifun),
        .out_srca(o_srca), .out_srcb(o_srcb), .out_dste(o_dste), .out_dstm(o_dstm),
        .out_vala(o_vala), .out_valb(o_valb), .out_valc(o_valc),
        .stall_cnt(o_scnt), .bubble_cnt(o_bcnt), .hazard_err(o_haz)
    );

    pipe_stage_reg #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_status(in_status),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_srca(in_srca), .in_srcb(in_srcb),
        .in_dste(in_dste), .in_dstm(in_dstm), .in_vala(in_vala), .in_valb(in_valb),
        .in_valc(in_valc), .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
        .out_valid(p_valid), .out_status(p_status), .out_icode(p_icode), .out_ifun(p_ifun),
        .out_srca(p_srca), .out_srcb(p_srcb), .out_dste(p_dste), .out_dstm(p_dstm),
        .out_vala(p_vala), .out_valb(p_valb), .out_valc(p_valc),
        .stall_cnt(p_scnt), .bubble_cnt(p_bcnt), .hazard_err(p_haz)
    );

    wire [218:0] bus16 = {o_valid, o_status, o_icode, o_ifun, o_srca, o_srcb, o_dste, o_dstm,
                          o_vala, o_valb, o_valc};
    wire [218:0] bus4  = {p_valid, p_status, p_icode, p_ifun, p_srca, p_srcb, p_dste, p_dstm,
                          p_vala, p_valb, p_valc};

    function automatic logic [218:0] exp_bus();
        return {m_valid, m_status, m_icode, m_ifun, m_srca, m_srcb, m_dste, m_dstm,
                m_vala, m_valb, m_valc};
    endfunction

    // A saturating counter of width w shows the event count capped at its all-ones value
    function automatic int sat(int n, int w);
        int top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    function automatic void model_nop();
        m_valid = 1'b0; m_status = 2'd0; m_icode = 4'h1; m_ifun = 4'h0;
        m_srca = 4'hF; m_srcb = 4'hF; m_dste = 4'hF; m_dstm = 4'hF;
        m_vala = '0; m_valb = '0; m_valc = '0;
    endfunction

    // Apply one clock edge of the rules to the model, then let the DUT take the same edge
    task automatic step();
        if (!reset_n) begin
            model_nop();
            m_sn = 0; m_bn = 0; m_haz = 1'b0;
        end else begin
            m_haz = stall && bubble;
            if (clr_cnt) begin
                m_sn = 0; m_bn = 0;
            end else if (bubble) m_bn++;
            else if (stall) m_sn++;
            if (bubble) model_nop();
            else if (!stall) begin
                m_valid = in_valid; m_status = in_status; m_icode = in_icode; m_ifun = in_ifun;
                m_srca = in_srca; m_srcb = in_srcb; m_dste = in_dste; m_dstm = in_dstm;
                m_vala = in_vala; m_valb = in_valb; m_valc = in_valc;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_in();
        in_valid = 1'($urandom); in_status = 2'($urandom);
        in_icode = 4'($urandom); in_ifun = 4'($urandom);
        in_srca = 4'($urandom); in_srcb = 4'($urandom);
        in_dste = 4'($urandom); in_dstm = 4'($urandom);
        in_vala = {$urandom, $urandom}; in_valb = {$urandom, $urandom};
        in_valc = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b1; bubble = 1'b0; clr_cnt = 1'b0;
        rand_in(); step();
        rand_in(); step();
        checks++;
        if (bus16 !== exp_bus()) begin
            errors++; $display("FAIL reset_bundle got=%h exp=%h", bus16, exp_bus());
        end
        checks++;
        if (o_icode !== 4'h1 || o_srca !== 4'hF || o_dstm !== 4'hF || o_valid !== 1'b0 || o_vala !== 64'h0) begin
            errors++; $display("FAIL reset_const icode=%h srca=%h dstm=%h valid=%b vala=%h", o_icode, o_srca, o_dstm, o_valid, o_vala);
        end
        checks++;
        if (o_scnt !== 16'd0 || o_bcnt !== 16'd0 || o_haz !== 1'b0) begin
            errors++; $display("FAIL reset_cnt scnt=%0d bcnt=%0d haz=%b exp 0 0 0", o_scnt, o_bcnt, o_haz);
        end
        reset_n = 1'b1; stall = 1'b0; bubble = 1'b0;
        rand_in(); in_icode = 4'h6; in_vala = 64'h5; in_valid = 1'b1;
        step();
        checks++;
        if (o_icode !== 4'h6 || o_vala !== 64'h5 || o_valid !== 1'b1) begin
            errors++; $display("FAIL reset_release icode=%h vala=%h valid=%b exp 6 5 1", o_icode, o_vala, o_valid);
        end
    endtask

    task automatic test_stall();
        rand_in(); in_valc = 64'hDEAD; step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in(); step();
            checks++;
            if (o_valc !== 64'hDEAD || bus16 !== exp_bus()) begin
                errors++; $display("FAIL stall_hold cyc=%0d valc=%h exp=dead bus=%h exp=%h", i, o_valc, bus16, exp_bus());
            end
        end
        checks++;
        if (o_scnt !== 16'd3) begin
            errors++; $display("FAIL stall_cnt got=%0d exp=3", o_scnt);
        end
        stall = 1'b0;
    endtask

    task automatic test_bubble();
        rand_in(); in_icode = 4'h5; in_dstm = 4'h3; bubble = 1'b1;
        step();
        checks++;
        if (o_icode !== 4'h1 || o_dstm !== 4'hF || o_valid !== 1'b0 || o_bcnt !== 16'd1) begin
            errors++; $display("FAIL bubble icode=%h dstm=%h valid=%b bcnt=%0d exp 1 f 0 1", o_icode, o_dstm, o_valid, o_bcnt);
        end
        bubble = 1'b0; rand_in(); step();
        checks++;
        if (bus16 !== exp_bus() || o_icode !== in_icode) begin
            errors++; $display("FAIL bubble_reload got=%h exp=%h", bus16, exp_bus());
        end
    endtask

    task automatic test_hazard();
        rand_in(); stall = 1'b1; bubble = 1'b1; step();
        checks++;
        if (o_haz !== 1'b1 || o_bcnt !== 16'd2 || o_scnt !== 16'd3 || o_icode !== 4'h1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL hazard haz=%b bcnt=%0d scnt=%0d icode=%h valid=%b exp 1 2 3 1 0", o_haz, o_bcnt, o_scnt, o_icode, o_valid);
        end
        stall = 1'b0; bubble = 1'b0; rand_in(); step();
        checks++;
        if (o_haz !== 1'b0) begin
            errors++; $display("FAIL hazard_pulse haz=%b exp=0", o_haz);
        end
    endtask

    task automatic test_back_to_back();
        bubble = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_in(); step();
        end
        bubble = 1'b0; stall = 1'b1; rand_in(); step();
        checks++;
        if (o_valid !== 1'b0 || o_icode !== 4'h1 || o_srcb !== 4'hF || bus16 !== exp_bus()) begin
            errors++; $display("FAIL b2b_nop valid=%b icode=%h srcb=%h exp 0 1 f", o_valid, o_icode, o_srcb);
        end
        stall = 1'b0;
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1; step();
        clr_cnt = 1'b0; stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_in(); step();
        end
        checks++;
        if (p_scnt !== 4'hF || o_scnt !== 16'd20) begin
            errors++; $display("FAIL saturate cnt4=%0d exp=15 cnt16=%0d exp=20", p_scnt, o_scnt);
        end
        clr_cnt = 1'b1; step();
        checks++;
        if (p_scnt !== 4'h0 || o_scnt !== 16'd0) begin
            errors++; $display("FAIL clr_wins cnt4=%0d cnt16=%0d exp 0 0", p_scnt, o_scnt);
        end
        clr_cnt = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        rand_in(); in_vala = 64'h7; step();
        stall = 1'b1; rand_in(); step();
        reset_n = 1'b0; rand_in(); step();
        checks++;
        if (o_vala !== 64'h0 || o_icode !== 4'h1 || o_scnt !== 16'd0) begin
            errors++; $display("FAIL reset_mid_stall vala=%h icode=%h scnt=%0d exp 0 1 0", o_vala, o_icode, o_scnt);
        end
        reset_n = 1'b1; stall = 1'b0; rand_in(); step();
        checks++;
        if (bus16 !== exp_bus()) begin
            errors++; $display("FAIL post_reset_load got=%h exp=%h", bus16, exp_bus());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 29) != 0);
            stall   = ($urandom_range(0, 2) == 0);
            bubble  = ($urandom_range(0, 4) == 0);
            clr_cnt = ($urandom_range(0, 39) == 0);
            rand_in(); step();
            checks++;
            if (bus16 !== exp_bus() || bus4 !== exp_bus()) begin
                errors++; $display("FAIL rand_bundle cyc=%0d got=%h exp=%h", i, bus16, exp_bus());
            end
            checks++;
            if (o_scnt !== 16'(sat(m_sn, 16)) || o_bcnt !== 16'(sat(m_bn, 16)) ||
                p_scnt !== 4'(sat(m_sn, 4)) || p_bcnt !== 4'(sat(m_bn, 4))) begin
                errors++; $display("FAIL rand_cnt cyc=%0d s16=%0d b16=%0d s4=%0d b4=%0d exp_events s=%0d b=%0d", i, o_scnt, o_bcnt, p_scnt, p_bcnt, m_sn, m_bn);
            end
            checks++;
            if (o_haz !== m_haz || p_haz !== m_haz) begin
                errors++; $display("FAIL rand_haz cyc=%0d got=%b/%b exp=%b", i, o_haz, p_haz, m_haz);
            end
        end
        reset_n = 1'b1; stall = 1'b0; bubble = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        m_sn = 0; m_bn = 0; m_haz = 1'b0;
        model_nop();
        test_reset();
        test_stall();
        test_bubble();
        test_hazard();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised Y86-64 pipeline stage register for any stage boundary (F/D, D/E, E/M, M/W).
- Captures the full instruction bundle: status, icode, ifun, register IDs, three data words and a valid bit.
- Supports synchronous active-low reset, stall (hold), and bubble (NOP injection with register IDs cleared to RNONE).
- Adds saturating stall/bubble event counters and a registered hazard-error flag for control-logic checking.

Parameters:
- WORD_W, 64, width of vala/valb/valc
- REG_W, 4, width of register-ID fields
- STAT_W, 2, width of status field
- NOP_ICODE, 4'h1, icode written on bubble/reset
- RNONE, 4'hF, register ID written to srca/srcb/dste/dstm on bubble/reset
- STAT_AOK, 2'd0, status written on bubble/reset
- CNT_W, 16, width of each event counter

Ports:
- clock  in  1  stage clock, rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  incoming bundle is a real instruction
- in_status  in  STAT_W  incoming status
- in_icode, in_ifun  in  4 each  incoming instruction code/function
- in_srca, in_srcb, in_dste, in_dstm  in  REG_W each  incoming register IDs
- in_vala, in_valb, in_valc  in  WORD_W each  incoming data words
- stall  in  1  hold current contents
- bubble  in  1  inject NOP
- clr_cnt  in  1  synchronous counter clear
- out_valid  out  1  registered valid
- out_status  out  STAT_W  registered status
- out_icode, out_ifun  out  4 each  registered codes
- out_srca, out_srcb, out_dste, out_dstm  out  REG_W each  registered register IDs
- out_vala, out_valb, out_valc  out  WORD_W each  registered data words
- stall_cnt  out  CNT_W  stall cycles counted
- bubble_cnt  out  CNT_W  bubble cycles counted
- hazard_err  out  1  stall and bubble were both high in the previous cycle

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising edge of clock). No asynchronous paths.
- All outputs are registered. Latency from input to output is 1 cycle.
- Per-edge priority: reset > bubble > stall > load.
- Reset (reset_n=0):
  - out_icode=NOP_ICODE, out_ifun=0.
  - out_srca/srcb/dste/dstm=RNONE.
  - out_vala/valb/valc=0, out_status=STAT_AOK, out_valid=0.
  - stall_cnt=0, bubble_cnt=0, hazard_err=0.
  - Reset mid-stall or mid-bubble discards state; the next edge with reset_n=1 acts normally.
- Bubble (bubble=1):
  - Bundle takes the reset values above (NOP, RNONE IDs, zero data, AOK, out_valid=0).
  - bubble_cnt increments.
  - Applies regardless of stall.
- Stall (stall=1, bubble=0):
  - All bundle outputs and out_valid hold.
  - stall_cnt increments.
- Load (stall=0, bubble=0): every out_* takes the matching in_*; out_valid<=in_valid.
- hazard_err<=stall&bubble each non-reset edge, so it is a 1-cycle pulse per offending cycle. When both are high, bubble wins and only bubble_cnt increments.
- Counters:
  - Saturate at all-ones and never wrap.
  - clr_cnt=1 clears both counters to 0 and takes precedence over an increment in the same cycle.
  - Reset also clears them.
- Back-to-back bubbles keep the NOP bundle; out_valid stays 0.
- A stall following a bubble holds the NOP bundle.

Test Plan:
- Reset: reset_n=0 for 2 edges with random inputs -> out_icode=1, all IDs=4'hF, data=0, out_valid=0, counters=0; release with stall=bubble=0, in_icode=6, in_vala=64'h5 -> next edge out_icode=6, out_vala=5, out_valid=1.
- Stall hold: load in_valc=64'hDEAD; assert stall 3 cycles while inputs change -> outputs stay 64'hDEAD; stall_cnt=3.
- Bubble: in_icode=5, in_dstm=4'h3, bubble=1 for 1 edge -> out_icode=1, out_dstm=4'hF, out_valid=0, bubble_cnt=1; next load edge shows new inputs.
- Simultaneous stall+bubble for 1 edge -> NOP bundle; bubble_cnt increments, stall_cnt unchanged; hazard_err=1 for exactly one cycle.
- Saturation with CNT_W=4: 20 stall cycles -> stall_cnt=4'hF. Then clr_cnt=1 with stall=1 on the same edge -> stall_cnt=0.
- Reset mid-stall: stall=1 with out_vala=64'h7, reset_n=0 for 1 edge -> out_vala=0, out_icode=1, stall_cnt=0.
